// File: rtl/nvme_pdu_engine.sv
// nvme_pdu_engine: builds an NVMe/TCP-style PDU in byte memory on write and streams it,
// plus a 4-char status, to a uart_tx on read.
module nvme_pdu_engine #(
  parameter int MAX_PAYLOAD = 64,
  parameter int MEM_AW = 8,
  parameter int LEN_W = 8,
  parameter logic [7:0] PDU_VERSION = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_start_i,
  input  logic             rd_start_i,
  input  logic [7:0]       opcode_i,
  input  logic [31:0]      nsid_i,
  input  logic [LEN_W-1:0] pay_len_i,
  input  logic [7:0]       pay_data_i,
  input  logic             pay_valid_i,
  output logic             pay_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_start_o,
  input  logic             tx_busy_i,
  output logic             busy_o,
  output logic [7:0]       cmd_id_o,
  output logic             pdu_valid_o
);
  localparam int PW = MEM_AW + 1;
  localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, PAY = 3'd2, RD_FETCH = 3'd3, RD_SEND = 3'd4, ACK = 3'd5;
  logic [2:0] state_q, state_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [PW-1:0] pdu_len_q, pdu_len_d;
  logic [7:0] cmd_id_q, cmd_id_d, op_q, op_d, tx_data_q, tx_data_d, rd_q;
  logic [31:0] nsid_q, nsid_d;
  logic pdu_valid_q, pdu_valid_d, ack_rd_q, ack_rd_d, ack_err_q, ack_err_d, tx_start_q, tx_start_d;
  logic [1:0] ack_idx_q, ack_idx_d, tx_ph_q, tx_ph_d;
  logic [7:0] mem [2**MEM_AW];
  logic mem_we, sending, tx_fire, tx_done, len_bad;
  logic [MEM_AW-1:0] mem_waddr;
  logic [7:0] mem_wdata, tx_byte;
  logic [63:0] hdr_w;
  logic [31:0] ack_w;
  assign hdr_w = {PDU_VERSION, op_q, 8'h00, cmd_id_q, nsid_q};
  assign ack_w = {ack_rd_q ? "R" : "W", " ", ack_err_q ? "ER" : "OK"};
  assign tx_byte = state_q == RD_SEND ? rd_q : ack_w[{~ack_idx_q, 3'b000} +: 8];
  assign sending = state_q == RD_SEND || state_q == ACK;
  // Per byte: phase 0 waits for an idle UART and fires, 1 waits for busy to rise, 2 for it to fall.
  assign tx_fire = sending && tx_ph_q == 2'd0 && !tx_busy_i;
  assign tx_done = sending && tx_ph_q == 2'd2 && !tx_busy_i;
  assign len_bad = pay_len_i == '0 || pay_len_i > LEN_W'(MAX_PAYLOAD);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    len_d = len_q;
    pdu_len_d = pdu_len_q;
    cmd_id_d = cmd_id_q;
    op_d = op_q;
    nsid_d = nsid_q;
    pdu_valid_d = pdu_valid_q;
    ack_rd_d = ack_rd_q;
    ack_err_d = ack_err_q;
    ack_idx_d = ack_idx_q;
    tx_start_d = tx_fire;
    tx_data_d = tx_fire ? tx_byte : tx_data_q;
    tx_ph_d = tx_fire ? 2'd1 : tx_done ? 2'd0 : (tx_ph_q == 2'd1 && tx_busy_i) ? 2'd2 : tx_ph_q;
    mem_we = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = hdr_w[{~idx_q[2:0], 3'b000} +: 8];
    case (state_q)
      IDLE:
        if (wr_start_i && len_bad) begin
          state_d = ACK;
          ack_rd_d = 1'b0;
          ack_err_d = 1'b1;
          ack_idx_d = 2'd0;
        end else if (wr_start_i) begin
          state_d = HDR;
          cmd_id_d = cmd_id_q + 8'd1;
          pdu_valid_d = 1'b0;
          op_d = opcode_i;
          nsid_d = nsid_i;
          len_d = pay_len_i;
          idx_d = '0;
        end else if (rd_start_i) begin
          state_d = pdu_valid_q ? RD_FETCH : ACK;
          ack_rd_d = 1'b1;
          ack_err_d = !pdu_valid_q;
          ack_idx_d = 2'd0;
          idx_d = '0;
        end
      HDR: begin
        mem_we = 1'b1;
        idx_d = idx_q + MEM_AW'(1);
        cnt_d = '0;
        state_d = idx_q == MEM_AW'(7) ? PAY : HDR;
      end
      PAY:
        if (pay_valid_i) begin
          mem_we = 1'b1;
          mem_waddr = MEM_AW'(8) + MEM_AW'(cnt_q);
          mem_wdata = pay_data_i;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ACK;
            pdu_len_d = PW'(len_q) + PW'(8);
            pdu_valid_d = 1'b1;
            ack_rd_d = 1'b0;
            ack_err_d = 1'b0;
            ack_idx_d = 2'd0;
          end
        end
      RD_FETCH: state_d = RD_SEND;
      RD_SEND:
        if (tx_done) begin
          idx_d = idx_q + MEM_AW'(1);
          state_d = PW'(idx_q) + PW'(1) == pdu_len_q ? ACK : RD_FETCH;
        end
      ACK:
        if (tx_done) begin
          ack_idx_d = ack_idx_q + 2'd1;
          state_d = ack_idx_q == 2'd3 ? IDLE : ACK;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      pdu_len_q <= '0;
      cmd_id_q <= '0;
      op_q <= '0;
      nsid_q <= '0;
      pdu_valid_q <= 1'b0;
      ack_rd_q <= 1'b0;
      ack_err_q <= 1'b0;
      ack_idx_q <= '0;
      tx_ph_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      pdu_len_q <= pdu_len_d;
      cmd_id_q <= cmd_id_d;
      op_q <= op_d;
      nsid_q <= nsid_d;
      pdu_valid_q <= pdu_valid_d;
      ack_rd_q <= ack_rd_d;
      ack_err_q <= ack_err_d;
      ack_idx_q <= ack_idx_d;
      tx_ph_q <= tx_ph_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
    end
  end
  // rd_q only loads in RD_FETCH so it stays put for the whole UART handshake.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state_q == RD_FETCH) rd_q <= mem[idx_q];
  end
  assign pay_ready_o = state_q == PAY;
  assign busy_o = state_q != IDLE;
  assign tx_start_o = tx_start_q;
  assign tx_data_o = tx_data_q;
  assign cmd_id_o = cmd_id_q;
  assign pdu_valid_o = pdu_valid_q;
endmodule

// File: tb/tb_nvme_pdu_engine.sv
// tb_nvme_pdu_engine: randomized write/read commands against a queue-based PDU model
// with a simple busy-for-N-cycles UART responder.
module tb_nvme_pdu_engine;
  localparam int MAXP = 64;
  logic clk = 0, rst = 1;
  logic wr_start = 0, rd_start = 0, pay_valid = 0, tx_busy = 0;
  logic [7:0] opcode = 0, pay_data = 0, pay_len = 0;
  logic [31:0] nsid = 0;
  logic pay_ready, tx_start, busy, pdu_valid;
  logic [7:0] tx_data, cmd_id;
  int n_cmp = 0, n_err = 0, viol = 0, ub = 0;
  int cmd_m = 0;
  bit valid_m = 0;
  logic [7:0] pdu_m[$], exp_q[$], cap[$], pl[$];
  always #5 clk = ~clk;
  nvme_pdu_engine #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst), .wr_start_i(wr_start), .rd_start_i(rd_start),
    .opcode_i(opcode), .nsid_i(nsid), .pay_len_i(pay_len), .pay_data_i(pay_data),
    .pay_valid_i(pay_valid), .pay_ready_o(pay_ready), .tx_data_o(tx_data),
    .tx_start_o(tx_start), .tx_busy_i(tx_busy), .busy_o(busy), .cmd_id_o(cmd_id),
    .pdu_valid_o(pdu_valid)
  );
  always @(negedge clk) begin
    if (tx_start) begin
      if (tx_busy) viol++;
      cap.push_back(tx_data);
      tx_busy = 1;
      ub = $urandom_range(2, 6);
    end else if (ub > 0) begin
      ub--;
      if (ub == 0) tx_busy = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction
  function automatic void rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction
  task automatic reset_outs(input string tag);
    chk({tag, "_pay_ready"}, pay_ready, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_id"}, cmd_id, 0);
    chk({tag, "_pdu_valid"}, pdu_valid, 0);
  endtask
  task automatic finish_cmd(input string tag);
    int t = 0;
    while (busy && t < 20000) begin
      tick();
      t++;
    end
    chk({tag, "_done"}, busy, 0);
    chk({tag, "_tx_n"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) chk({tag, "_tx_byte"}, cap[i], exp_q[i]);
    chk({tag, "_cmd_id"}, cmd_id, cmd_m);
    chk({tag, "_pdu_valid"}, pdu_valid, valid_m);
    chk({tag, "_proto"}, viol, 0);
  endtask
  task automatic do_write(input string tag, input logic [7:0] op, input logic [31:0] ns,
                          input int len, input bit both, input bit gaps);
    int k = 0, t = 0;
    bit bad = len == 0 || len > MAXP;
    cap.delete();
    exp_q.delete();
    if (bad) push_str("W ER");
    else begin
      cmd_m = (cmd_m + 1) % 256;
      valid_m = 1;
      pdu_m = '{8'h01, op, 8'h00, 8'(cmd_m), ns[31:24], ns[23:16], ns[15:8], ns[7:0]};
      foreach (pl[i]) pdu_m.push_back(pl[i]);
      push_str("W OK");
    end
    opcode = op;
    nsid = ns;
    pay_len = 8'(len);
    wr_start = 1;
    rd_start = both;
    tick();
    wr_start = 0;
    rd_start = 0;
    while (!bad && k < len && t < 5000) begin
      pay_valid = gaps ? (t % 2) == 1 : 1'b1;
      pay_data = pl[k];
      rd_start = both && t == 2;
      @(negedge clk);
      if (pay_valid && pay_ready) k++;
      tick();
      t++;
    end
    pay_valid = 0;
    rd_start = 0;
    if (!bad) chk({tag, "_pay_cnt"}, k, len);
    finish_cmd(tag);
  endtask
  task automatic do_read(input string tag);
    cap.delete();
    exp_q.delete();
    if (valid_m) begin
      exp_q = pdu_m;
      push_str("R OK");
    end else push_str("R ER");
    rd_start = 1;
    tick();
    rd_start = 0;
    finish_cmd(tag);
  endtask
  initial begin
    string hello = "Hello NVMe/TCP!";
    repeat (3) tick();
    reset_outs("rst");
    rst = 0;
    tick();
    do_read("rd_empty");
    pl.delete();
    for (int i = 0; i < hello.len(); i++) pl.push_back(hello[i]);
    do_write("wr_hello", 8'h01, 32'h1, 15, 0, 0);
    do_read("rd_hello");
    chk("rd_hello_pulses", cap.size(), 27);
    pl.delete();
    do_write("wr_len0", 8'h02, 32'h5, 0, 0, 0);
    do_write("wr_len_big", 8'h02, 32'h5, MAXP + 1, 0, 0);
    do_read("rd_after_bad");
    rand_pl(3);
    do_write("wr_both", 8'h7e, $urandom, 3, 1, 1);
    chk("wr_both_only_ack", cap.size(), 4);
    do_read("rd_both");
    rand_pl(MAXP);
    do_write("wr_max", 8'($urandom), $urandom, MAXP, 0, 1);
    do_read("rd_max");
    for (int n = 0; n < 256; n++) begin
      int len = $urandom_range(1, 4);
      rand_pl(len);
      do_write("wr_wrap", 8'($urandom), $urandom, len, 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) do_read("rd_wrap");
    end
    rand_pl(10);
    opcode = 8'h33;
    pay_len = 8'd10;
    wr_start = 1;
    tick();
    wr_start = 0;
    pay_valid = 1;
    for (int i = 0; i < 11; i++) begin
      pay_data = pl[i % 10];
      tick();
    end
    chk("rst_in_pay", pay_ready, 1);
    cap.delete();
    rst = 1;
    #2;
    reset_outs("rst_mid");
    pay_valid = 0;
    tick();
    rst = 0;
    cmd_m = 0;
    valid_m = 0;
    pdu_m.delete();
    repeat (50) tick();
    chk("rst_quiet", cap.size(), 0);
    chk("rst_idle", busy, 0);
    do_read("rd_after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
